run_sequencer: RTL and testbench

//  Sequences program execution for the 9-bit core: owns the program counter,

---
 rtl/seq_pkg.sv | 8 +
 rtl/next_pc_calc.sv | 32 +++
 rtl/run_sequencer.sv | 107 ++++++++++
 tb/tb_run_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the run sequencer of the 9-bit core.
package seq_pkg;
   typedef enum logic [1:0] {IDLE, RUN, LOAD, DONE} seq_state_t;

   localparam int PC_W_DEF = 10;
   localparam int LAT_W = 3;
   localparam logic [8:0] HALT_INSTR = 9'h1FF;
endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for a RUN cycle: absolute jump, relative
// branch-if-not-zero, or sequential step, all modulo 2**PC_W.
module next_pc_calc
   import seq_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) (
   input  logic [PC_W-1:0] pc,
   input  logic            jump,
   input  logic            branch_rel_en,
   input  logic            zero,
   input  logic [PC_W-1:0] abs_target,
   input  logic [7:0]      rel_offset,
   output logic [PC_W-1:0] next_pc
);

   logic [PC_W-1:0] offset_ext;

   // Size cast of a signed operand sign-extends the 8-bit offset.
   assign offset_ext = PC_W'($signed(rel_offset));

   always_comb begin
      // NOTE: default assignment first so no path leaves next_pc unassigned (no latch).
      next_pc = pc + PC_W'(1);
      if (jump) begin
         next_pc = abs_target;
      end else if (branch_rel_en && !zero) begin
         next_pc = pc + offset_ext;
      end
   end

endmodule

// File: rtl/run_sequencer.sv
// Program sequencer: PC, start/done handshake, load-latency stall and
// write-enable gating so architectural state only changes while running.
module run_sequencer
   import seq_pkg::*;
#(
   parameter int PC_W       = PC_W_DEF,
   parameter int START_ADDR = 0,
   parameter int LOAD_LAT   = 1,
   parameter int CNT_W      = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Ack,
   input  logic             Jump,
   input  logic             BranchRelEn,
   input  logic             Zero,
   input  logic             LoadInst,
   input  logic             RegWrEn,
   input  logic             MemWrEn,
   input  logic [PC_W-1:0]  AbsTarget,
   input  logic [7:0]       RelOffset,
   output logic [PC_W-1:0]  ProgCtr,
   output logic             RegWrOut,
   output logic             MemWrOut,
   output logic             Running,
   output logic             Done,
   output logic [CNT_W-1:0] CycleCount
);

   localparam logic             HAS_LAT   = (LOAD_LAT > 0);
   localparam logic [LAT_W-1:0] LOAD_INIT = LAT_W'((LOAD_LAT > 0) ? LOAD_LAT - 1 : 0);
   localparam logic [PC_W-1:0]  PC_START  = PC_W'(START_ADDR);

   seq_state_t       state_q;
   logic [PC_W-1:0]  pc_q;
   logic [LAT_W-1:0] load_cnt_q;
   logic [CNT_W-1:0] cycle_q;
   logic [PC_W-1:0]  pc_next;
   logic             load_stall;
   logic             run_exec;
   logic             load_last;

   next_pc_calc #(.PC_W(PC_W)) u_next_pc (
      .pc            (pc_q),
      .jump          (Jump),
      .branch_rel_en (BranchRelEn),
      .zero          (Zero),
      .abs_target    (AbsTarget),
      .rel_offset    (RelOffset),
      .next_pc       (pc_next)
   );

   assign load_stall = LoadInst && HAS_LAT;
   // The halt cycle is in RUN but must not commit any write.
   assign run_exec   = (state_q == RUN) && !Ack;
   assign load_last  = (state_q == LOAD) && (load_cnt_q == '0);

   assign RegWrOut   = (run_exec && RegWrEn && !load_stall) || load_last;
   assign MemWrOut   = run_exec && MemWrEn;
   assign Running    = (state_q == RUN) || (state_q == LOAD);
   assign Done       = (state_q == DONE);
   assign ProgCtr    = pc_q;
   assign CycleCount = cycle_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!Reset_n) begin
         state_q    <= IDLE;
         pc_q       <= PC_START;
         load_cnt_q <= '0;
         cycle_q    <= '0;
      end else if (Start) begin
         state_q    <= IDLE;
         pc_q       <= PC_START;
         load_cnt_q <= '0;
         cycle_q    <= '0;
      end else begin
         if (Running && (cycle_q != {CNT_W{1'b1}})) begin
            cycle_q <= cycle_q + CNT_W'(1);
         end
         case (state_q)
            IDLE: state_q <= RUN;
            RUN: begin
               if (Ack) begin
                  state_q <= DONE;
               end else if (load_stall) begin
                  state_q    <= LOAD;
                  load_cnt_q <= LOAD_INIT;
               end else begin
                  pc_q <= pc_next;
               end
            end
            LOAD: begin
               if (load_cnt_q == '0) begin
                  state_q <= RUN;
                  pc_q    <= pc_q + PC_W'(1);
               end else begin
                  load_cnt_q <= load_cnt_q - LAT_W'(1);
               end
            end
            DONE: state_q <= DONE;
         endcase
      end
   end

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench: two sequencers (load latency 2 and 0) share stimulus and
// are compared every cycle against a behavioural model, plus directed literals.
module tb_run_sequencer;

   logic       Clk;
   logic       Reset_n;
   logic       Start, Ack, Jump, BranchRelEn, Zero, LoadInst, RegWrEn, MemWrEn;
   logic [9:0] AbsTarget;
   logic [7:0] RelOffset;

   logic [9:0]  pc_a, pc_b;
   logic        rw_a, rw_b, mw_a, mw_b, run_a, run_b, done_a, done_b;
   logic [15:0] cc_a, cc_b;

   int n_checks = 0;
   int n_fail   = 0;

   run_sequencer #(.PC_W(10), .START_ADDR(0), .LOAD_LAT(2), .CNT_W(16)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack), .Jump(Jump),
      .BranchRelEn(BranchRelEn), .Zero(Zero), .LoadInst(LoadInst),
      .RegWrEn(RegWrEn), .MemWrEn(MemWrEn), .AbsTarget(AbsTarget),
      .RelOffset(RelOffset), .ProgCtr(pc_a), .RegWrOut(rw_a), .MemWrOut(mw_a),
      .Running(run_a), .Done(done_a), .CycleCount(cc_a)
   );

   run_sequencer #(.PC_W(10), .START_ADDR(0), .LOAD_LAT(0), .CNT_W(16)) dut0 (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack), .Jump(Jump),
      .BranchRelEn(BranchRelEn), .Zero(Zero), .LoadInst(LoadInst),
      .RegWrEn(RegWrEn), .MemWrEn(MemWrEn), .AbsTarget(AbsTarget),
      .RelOffset(RelOffset), .ProgCtr(pc_b), .RegWrOut(rw_b), .MemWrOut(mw_b),
      .Running(run_b), .Done(done_b), .CycleCount(cc_b)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: active = executing (RUN or stalled), stall = LOAD cycles still to go.
   typedef struct {
      bit active;
      bit done;
      int stall;
      int pc;
      int cycles;
   } model_t;

   model_t m2, m0;

   function automatic model_t model_reset();
      model_t r;
      r.active = 0; r.done = 0; r.stall = 0; r.pc = 0; r.cycles = 0;
      return r;
   endfunction

   function automatic model_t model_step(input model_t m, input int lat);
      model_t n = m;
      if (Start) begin
         n = model_reset();
      end else if (m.done) begin
         n = m;
      end else if (!m.active) begin
         n.active = 1;
      end else begin
         if (m.cycles < 65535) n.cycles = m.cycles + 1;
         if (m.stall > 0) begin
            n.stall = m.stall - 1;
            if (n.stall == 0) n.pc = (m.pc + 1) % 1024;
         end else if (Ack) begin
            n.active = 0;
            n.done   = 1;
         end else if (LoadInst && lat > 0) begin
            n.stall = lat;
         end else if (Jump) begin
            n.pc = int'(AbsTarget);
         end else if (BranchRelEn && !Zero) begin
            n.pc = ((m.pc + int'($signed(RelOffset))) % 1024 + 1024) % 1024;
         end else begin
            n.pc = (m.pc + 1) % 1024;
         end
      end
      return n;
   endfunction

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         m2 <= model_reset();
         m0 <= model_reset();
      end else begin
         m2 <= model_step(m2, 2);
         m0 <= model_step(m0, 0);
      end
   end

   task automatic cmp(input string tag, input model_t m, input int lat,
                      input logic [9:0] pc, input logic rw, input logic mw,
                      input logic run, input logic dn, input logic [15:0] cc);
      bit exp_rw, exp_mw;
      exp_rw = m.active && ((m.stall == 1) ||
               (m.stall == 0 && !Ack && RegWrEn && !(LoadInst && lat > 0)));
      exp_mw = m.active && (m.stall == 0) && !Ack && MemWrEn;
      check({tag, "_pc"},      32'(pc),  32'(m.pc));
      check({tag, "_regwr"},   32'(rw),  32'(exp_rw));
      check({tag, "_memwr"},   32'(mw),  32'(exp_mw));
      check({tag, "_running"}, 32'(run), 32'(m.active));
      check({tag, "_done"},    32'(dn),  32'(m.done));
      check({tag, "_cycles"},  32'(cc),  32'(m.cycles));
   endtask

   always @(negedge Clk) begin
      cmp("lat2", m2, 2, pc_a, rw_a, mw_a, run_a, done_a, cc_a);
      cmp("lat0", m0, 0, pc_b, rw_b, mw_b, run_b, done_b, cc_b);
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic ack, input logic jump, input logic br,
                        input logic zero, input logic ld, input logic rw,
                        input logic mw, input logic [9:0] abs_t, input logic [7:0] off);
      Ack = ack; Jump = jump; BranchRelEn = br; Zero = zero; LoadInst = ld;
      RegWrEn = rw; MemWrEn = mw; AbsTarget = abs_t; RelOffset = off;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset_n = 1'b0;
      Start   = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'd0);
      #12;
      check("rst_pc", 32'(pc_a), 0);
      check("rst_done", 32'(done_a), 0);
      check("rst_running", 32'(run_a), 0);
      check("rst_cycles", 32'(cc_a), 0);
      Reset_n = 1'b1;
      tick();

      // Plain run of five ops then halt
      Start = 1'b0;
      tick();
      check("t2_running", 32'(run_a), 1);
      for (int i = 0; i < 6; i++) begin
         check("t2_pc", 32'(pc_a), 32'(i));
         if (i < 5) drive(0, 0, 0, 0, 0, 1, 0, 10'd0, 8'd0);
         else       drive(1, 0, 0, 0, 0, 1, 1, 10'd0, 8'd0);
         #1;
         check("t2_regwr", 32'(rw_a), (i < 5) ? 32'd1 : 32'd0);
         if (i == 5) check("t2_memwr_ack", 32'(mw_a), 0);
         tick();
      end
      check("t2_done", 32'(done_a), 1);
      check("t2_cycles", 32'(cc_a), 6);
      check("t2_pc_hold", 32'(pc_a), 5);

      // DONE ignores decoder inputs and suppresses writes
      drive(0, 1, 0, 0, 0, 1, 1, 10'd77, 8'd0);
      #1;
      check("t6_memwr_done", 32'(mw_a), 0);
      check("t6_regwr_done", 32'(rw_a), 0);
      tick();
      check("t6_pc_done", 32'(pc_a), 5);
      check("t6_done_held", 32'(done_a), 1);
      Start = 1'b1;
      tick();
      check("t6_done_clr", 32'(done_a), 0);
      check("t6_pc_start", 32'(pc_a), 0);
      check("t6_cycles_clr", 32'(cc_a), 0);
      #1;
      check("t6_memwr_idle", 32'(mw_a), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'd0);
      Start = 1'b0;
      tick();

      // Branch arithmetic and wrap
      drive(0, 1, 0, 0, 0, 0, 0, 10'd10, 8'd0);   tick();
      check("t3_jump10", 32'(pc_a), 10);
      drive(0, 0, 1, 0, 0, 0, 0, 10'd0, 8'hFC);   tick();
      check("t3_br_taken", 32'(pc_a), 6);
      drive(0, 1, 0, 0, 0, 0, 0, 10'd10, 8'd0);   tick();
      drive(0, 0, 1, 1, 0, 0, 0, 10'd0, 8'hFC);   tick();
      check("t3_br_not_taken", 32'(pc_a), 11);
      drive(0, 1, 0, 0, 0, 0, 0, 10'd1023, 8'd0); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'd0);    tick();
      check("t3_wrap", 32'(pc_a), 0);
      drive(0, 1, 0, 0, 0, 0, 0, 10'd2, 8'd0);    tick();
      drive(0, 0, 1, 0, 0, 0, 0, 10'd0, 8'hFB);   tick();
      check("t3_br_under", 32'(pc_a), 1021);
      check("t3_cycles", 32'(cc_a), 8);

      // Jump beats branch; halt beats jump
      drive(0, 1, 1, 0, 0, 0, 0, 10'd300, 8'd5);  tick();
      check("t4_jump_wins", 32'(pc_a), 300);
      drive(1, 1, 0, 0, 0, 0, 0, 10'd7, 8'd0);    tick();
      check("t4_ack_done", 32'(done_a), 1);
      check("t4_ack_pc", 32'(pc_a), 300);
      check("t4_cycles", 32'(cc_a), 10);

      // Restart, then Start pulse mid-run
      drive(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'd0);
      Start = 1'b1; tick();
      Start = 1'b0; tick();
      tick();
      check("t6_run_pc1", 32'(pc_a), 1);
      Start = 1'b1; tick();
      check("t6_run_pc", 32'(pc_a), 0);
      check("t6_run_idle", 32'(run_a), 0);
      check("t6_run_cycles", 32'(cc_a), 0);
      Start = 1'b0; tick();

      // Load stall: latency 2 holds PC for three cycles, latency 0 for one
      for (int i = 0; i < 4; i++) tick();
      check("t5_pc_load", 32'(pc_a), 4);
      drive(0, 0, 0, 0, 1, 1, 0, 10'd0, 8'd0);
      #1;
      check("t5_rw_c1", 32'(rw_a), 0);
      check("t5_lat0_rw", 32'(rw_b), 1);
      tick();
      check("t5_lat0_pc", 32'(pc_b), 5);
      drive(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'd0);
      #1;
      check("t5_pc_c2", 32'(pc_a), 4);
      check("t5_rw_c2", 32'(rw_a), 0);
      tick();
      check("t5_pc_c3", 32'(pc_a), 4);
      check("t5_rw_c3", 32'(rw_a), 1);
      tick();
      check("t5_pc_after", 32'(pc_a), 5);
      check("t5_rw_after", 32'(rw_a), 0);

      // Asynchronous reset in the middle of a load stall
      drive(0, 0, 0, 0, 1, 1, 0, 10'd0, 8'd0);
      tick();
      check("t1_in_load", 32'(run_a), 1);
      drive(0, 0, 0, 0, 0, 0, 0, 10'd0, 8'd0);
      #1;
      Reset_n = 1'b0;
      #1;
      check("t1_pc", 32'(pc_a), 0);
      check("t1_regwr", 32'(rw_a), 0);
      check("t1_done", 32'(done_a), 0);
      check("t1_running", 32'(run_a), 0);
      check("t1_cycles", 32'(cc_a), 0);
      Start = 1'b1;
      #1;
      Reset_n = 1'b1;
      tick();
      Start = 1'b0;
      tick();
      tick();
      check("t1_restart_pc", 32'(pc_a), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
